// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if
// Bundles every signal between the arbiter, its two requesters and the SPI core.
//
// Handshake semantics (one place, applies to both requesters):
//   reqN_valid  : requester holds it high while it wants a transfer. It is
//                 treated as a fresh request whenever the arbiter is idle.
//                 The requester drops it once it sees reqN_busy=1.
//   reqN_busy   : the request was accepted and is in flight; fields were
//                 captured on the grant edge and may change freely afterwards.
//   reqN_done   : one-cycle pulse when the transfer completes; reqN_rdata is
//                 valid in that same cycle for reads.
//   reqN_err    : one-cycle pulse when the core never acknowledged (timeout
//                 build only; constant 0 otherwise).
//   spi_en      : held high from grant until the core raises spi_busy.
//   spi_busy    : core status; its falling edge ends a transfer.
//
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus SPI core)

interface spi_bus_arbiter_if;
  logic       req0_valid, req1_valid;
  logic       req0_rw, req1_rw;
  logic [5:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_busy, req1_busy;
  logic       req0_done, req1_done;
  logic [7:0] req0_rdata, req1_rdata;
  logic       req0_err, req1_err;
  logic       spi_en, spi_rw;
  logic [5:0] spi_address;
  logic [7:0] spi_wdata;
  logic       spi_busy;
  logic [7:0] spi_rdata;

  modport slave (
    input  req0_valid, req1_valid, req0_rw, req1_rw,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata,
    input  spi_busy, spi_rdata,
    output req0_busy, req1_busy, req0_done, req1_done,
    output req0_rdata, req1_rdata, req0_err, req1_err,
    output spi_en, spi_rw, spi_address, spi_wdata
  );

  modport master (
    output req0_valid, req1_valid, req0_rw, req1_rw,
    output req0_addr, req1_addr, req0_wdata, req1_wdata,
    output spi_busy, spi_rdata,
    input  req0_busy, req1_busy, req0_done, req1_done,
    input  req0_rdata, req1_rdata, req0_err, req1_err,
    input  spi_en, spi_rw, spi_address, spi_wdata
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// Shares one SPI core between two requesters with round-robin arbitration.
// FSM: IDLE -> ISSUE (spi_en high, waiting for the core to go busy)
//           -> WAIT_DONE (waiting for the core to finish) -> IDLE.
//
// Ports:
//   clk        - system clock, everything on posedge
//   rst        - synchronous, active-high reset
//   bus        - spi_bus_arbiter_if.slave (requester and SPI core signals)
//   fsm_state  - debug view of the FSM: 0=IDLE, 1=ISSUE, 2=WAIT_DONE
//
// Parameter:
//   ACK_TIMEOUT - cycles allowed in ISSUE for spi_busy to rise
//
// Build option:
//   SPI_ARB_TIMEOUT_EN - when defined, ISSUE gives up after ACK_TIMEOUT cycles
//   and pulses reqN_err; when undefined there is no counter and ISSUE waits
//   indefinitely.

module spi_bus_arbiter #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  spi_bus_arbiter_if.slave bus,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       last_grant, last_grant_n;
  logic       owner, owner_n;      // requester that owns the current transfer
  logic       pick;                // requester chosen in IDLE this cycle
  logic       spi_en_q, spi_en_n;
  logic       spi_rw_q, spi_rw_n;
  logic [5:0] addr_q, addr_n;
  logic [7:0] wdata_q, wdata_n;
  logic [1:0] busy_q, busy_n;
  logic [1:0] done_q, done_n;
  logic [7:0] rdata0_q, rdata0_n;
  logic [7:0] rdata1_q, rdata1_n;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0]    err_q, err_n;
`endif

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    owner_n      = owner;
    pick         = 1'b0;
    spi_en_n     = spi_en_q;
    spi_rw_n     = spi_rw_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    busy_n       = busy_q;
    done_n       = 2'b00;
    rdata0_n     = rdata0_q;
    rdata1_n     = rdata1_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_n        = cnt_q;
    err_n        = 2'b00;
`endif
    case (state)
      IDLE: begin
        // The bus is only free once the core reports idle, which also covers
        // a transfer left running across a reset.
        if (!bus.spi_busy && (bus.req0_valid || bus.req1_valid)) begin
          // On a tie, serve whoever was not served last; otherwise the one asking.
          pick     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
          owner_n  = pick;
          spi_en_n = 1'b1;
          spi_rw_n = pick ? bus.req1_rw    : bus.req0_rw;
          addr_n   = pick ? bus.req1_addr  : bus.req0_addr;
          wdata_n  = pick ? bus.req1_wdata : bus.req0_wdata;
          busy_n   = pick ? 2'b10 : 2'b01;
          state_n  = ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_n    = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.spi_busy) begin
          spi_en_n = 1'b0;
          state_n  = WAIT_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          spi_en_n     = 1'b0;
          busy_n       = 2'b00;
          err_n        = owner ? 2'b10 : 2'b01;
          last_grant_n = owner;
          state_n      = IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.spi_busy) begin
          if (spi_rw_q) begin
            if (owner) rdata1_n = bus.spi_rdata;
            else       rdata0_n = bus.spi_rdata;
          end
          busy_n       = 2'b00;
          done_n       = owner ? 2'b10 : 2'b01;
          last_grant_n = owner;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      spi_en_q   <= 1'b0;
      spi_rw_q   <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= '0;
`endif
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      owner      <= owner_n;
      spi_en_q   <= spi_en_n;
      spi_rw_q   <= spi_rw_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      rdata0_q   <= rdata0_n;
      rdata1_q   <= rdata1_n;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q      <= cnt_n;
      err_q      <= err_n;
`endif
    end
  end

  assign bus.spi_en      = spi_en_q;
  assign bus.spi_rw      = spi_rw_q;
  assign bus.spi_address = addr_q;
  assign bus.spi_wdata   = wdata_q;
  assign bus.req0_busy   = busy_q[0];
  assign bus.req1_busy   = busy_q[1];
  assign bus.req0_done   = done_q[0];
  assign bus.req1_done   = done_q[1];
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.req0_err    = err_q[0];
  assign bus.req1_err    = err_q[1];
`else
  assign bus.req0_err    = 1'b0;
  assign bus.req1_err    = 1'b0;
`endif
  assign fsm_state       = state;

endmodule
